hbm_traffic_sequencer: RTL and testbench

Drives the HBM memory-command port from the UART control outputs (`start`, `read_write`, `address_inc`). It issues read/write commands over a valid/ready handshake and tracks outstanding commands up to a programmable depth. It also keeps issue and completion counts for status readback. It sits between the UART command decoder and the HBM port adapter.

---
 rtl/hbm_traffic_sequencer.sv | 138 +++++++++++++
 tb/tb_hbm_traffic_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hbm_traffic_sequencer.sv
// HBM command sequencer: turns UART run controls into valid/ready read/write commands,
// tracks outstanding commands and keeps issue/completion counts for readback.
module hbm_traffic_sequencer #(
  parameter int unsigned ADDR_W    = 33,
  parameter int unsigned ADDR_STEP = 32,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned MAX_OUT   = 8
) (
  input  logic              clk,
  input  logic              Reset_n,
  input  logic              start,
  input  logic [2:0]        read_write,
  input  logic              address_inc,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_write,
  output logic [ADDR_W-1:0] cmd_addr,
  input  logic              rsp_valid,
  output logic              busy,
  output logic [31:0]       issued_count,
  output logic [31:0]       completed_count,
  output logic              err_unexpected
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDrain} state_e;

  localparam logic [7:0]        MaxOut   = 8'(MAX_OUT);
  localparam logic [ADDR_W-1:0] AddrStep = ADDR_W'(ADDR_STEP);
  localparam logic [ADDR_W-1:0] AddrBase = ADDR_W'(BASE_ADDR);

  state_e              state_q;
  logic [2:0]          mode_q;
  logic                inc_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                valid_q, write_q, busy_q, err_q;
  logic [7:0]          out_q;
  logic [31:0]         issued_q, completed_q;

  logic                accept, rsp_ok, queued, can_issue, advance;
  logic [7:0]          out_d;

  always_comb begin
    accept    = valid_q & cmd_ready;
    rsp_ok    = rsp_valid & (out_q != 8'd0);
    out_d     = out_q + {7'd0, accept} - {7'd0, rsp_ok};
    queued    = (mode_q == 3'd3) || (mode_q == 3'd4);
    can_issue = out_d < MaxOut;
    // In alternate mode the address only moves once the read of the pair is accepted.
    advance   = accept & inc_q & ~((mode_q == 3'd2) & write_q);
  end

  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      state_q     <= StIdle;
      mode_q      <= 3'd0;
      inc_q       <= 1'b0;
      addr_q      <= '0;
      valid_q     <= 1'b0;
      write_q     <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      out_q       <= 8'd0;
      issued_q    <= 32'd0;
      completed_q <= 32'd0;
    end else begin
      if (rsp_valid && (out_q == 8'd0)) err_q <= 1'b1;
      if (state_q != StIdle) begin
        out_q <= out_d;
        if (accept) issued_q <= issued_q + 32'd1;
        if (rsp_ok) completed_q <= completed_q + 32'd1;
        if (advance) addr_q <= addr_q + AddrStep;
        if (accept && (mode_q == 3'd2)) write_q <= ~write_q;
      end
      unique case (state_q)
        StIdle: begin
          if (start && (read_write <= 3'd4)) begin
            state_q     <= StIssue;
            busy_q      <= 1'b1;
            valid_q     <= 1'b1;
            mode_q      <= read_write;
            inc_q       <= address_inc;
            addr_q      <= AddrBase;
            write_q     <= (read_write == 3'd1) || (read_write == 3'd2) || (read_write == 3'd4);
            issued_q    <= 32'd0;
            completed_q <= 32'd0;
            out_q       <= 8'd0;
            err_q       <= 1'b0;
          end
        end
        StIssue: begin
          if (valid_q && !cmd_ready) begin
            // Hold the pending request until it is accepted, whatever start does.
          end else if (!start) begin
            valid_q <= 1'b0;
            if (out_d == 8'd0) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end else begin
              state_q <= StDrain;
            end
          end else if (!queued) begin
            valid_q <= 1'b0;
            state_q <= StWait;
          end else begin
            valid_q <= can_issue;
          end
        end
        StWait: begin
          if (rsp_ok) begin
            if (start) begin
              state_q <= StIssue;
              valid_q <= 1'b1;
            end else begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end
          end
        end
        StDrain: begin
          if (out_d == 8'd0) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_valid       = valid_q;
  assign cmd_write       = write_q;
  assign cmd_addr        = addr_q;
  assign busy            = busy_q;
  assign issued_count    = issued_q;
  assign completed_count = completed_q;
  assign err_unexpected  = err_q;

endmodule

// File: tb/tb_hbm_traffic_sequencer.sv
// Directed bench for hbm_traffic_sequencer: default instance plus a narrow-address
// instance for wrap-around.
module tb_hbm_traffic_sequencer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        Reset_n = 1'b0;
  logic        start = 1'b0, address_inc = 1'b0, cmd_ready = 1'b0, rsp_valid = 1'b0;
  logic [2:0]  read_write = 3'd0;
  logic        cmd_valid, cmd_write, busy, err_unexpected;
  logic [32:0] cmd_addr;
  logic [31:0] issued_count, completed_count;

  logic        start_w = 1'b0, inc_w = 1'b0, ready_w = 1'b0, rsp_w = 1'b0;
  logic [2:0]  rw_w = 3'd0;
  logic        valid_w, write_w, busy_w, err_w;
  logic [5:0]  addr_w;
  logic [31:0] issued_w, completed_w;

  hbm_traffic_sequencer u_dut (
    .clk             (clk),
    .Reset_n         (Reset_n),
    .start           (start),
    .read_write      (read_write),
    .address_inc     (address_inc),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_write       (cmd_write),
    .cmd_addr        (cmd_addr),
    .rsp_valid       (rsp_valid),
    .busy            (busy),
    .issued_count    (issued_count),
    .completed_count (completed_count),
    .err_unexpected  (err_unexpected)
  );

  hbm_traffic_sequencer #(
    .ADDR_W    (6),
    .ADDR_STEP (32),
    .BASE_ADDR (32),
    .MAX_OUT   (8)
  ) u_dut_w (
    .clk             (clk),
    .Reset_n         (Reset_n),
    .start           (start_w),
    .read_write      (rw_w),
    .address_inc     (inc_w),
    .cmd_valid       (valid_w),
    .cmd_ready       (ready_w),
    .cmd_write       (write_w),
    .cmd_addr        (addr_w),
    .rsp_valid       (rsp_w),
    .busy            (busy_w),
    .issued_count    (issued_w),
    .completed_count (completed_w),
    .err_unexpected  (err_w)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  int acc;

  initial begin
    tick();
    tick();
    check("rst_valid", 64'(cmd_valid), 64'd0);
    check("rst_write", 64'(cmd_write), 64'd0);
    check("rst_addr", 64'(cmd_addr), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_issued", 64'(issued_count), 64'd0);
    check("rst_completed", 64'(completed_count), 64'd0);
    check("rst_err", 64'(err_unexpected), 64'd0);
    Reset_n = 1'b1;
    tick();

    // Mode 1 write, stepping address, response two cycles after each accept.
    read_write = 3'd1; address_inc = 1'b1; cmd_ready = 1'b1; start = 1'b1;
    tick();
    check("t1_busy", 64'(busy), 64'd1);
    check("t1_valid", 64'(cmd_valid), 64'd1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t1_addr%0d", i), 64'(cmd_addr), 64'(i * 32));
      check($sformatf("t1_write%0d", i), 64'(cmd_write), 64'd1);
      if (i == 3) start = 1'b0;
      tick();
      check($sformatf("t1_wait%0d", i), 64'(cmd_valid), 64'd0);
      tick();
      rsp_valid = 1'b1;
      tick();
      rsp_valid = 1'b0;
    end
    check("t1_idle", 64'(busy), 64'd0);
    check("t1_issued", 64'(issued_count), 64'd4);
    check("t1_completed", 64'(completed_count), 64'd4);

    // Mode 2 alternate, fixed address: W0 R0 W0 R0.
    read_write = 3'd2; address_inc = 1'b0; start = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_write%0d", i), 64'(cmd_write), (i % 2 == 0) ? 64'd1 : 64'd0);
      check($sformatf("t2_addr%0d", i), 64'(cmd_addr), 64'd0);
      if (i == 3) start = 1'b0;
      tick();
      tick();
      rsp_valid = 1'b1;
      tick();
      rsp_valid = 1'b0;
    end
    check("t2_idle", 64'(busy), 64'd0);
    check("t2_issued", 64'(issued_count), 64'd4);
    check("t2_completed", 64'(completed_count), 64'd4);

    // Mode 3 queued read with withheld responses.
    read_write = 3'd3; address_inc = 1'b1; start = 1'b1; acc = 0;
    tick();
    repeat (12) begin
      if (cmd_valid) acc++;
      tick();
    end
    check("t3_accepts8", 64'(acc), 64'd8);
    check("t3_full_valid", 64'(cmd_valid), 64'd0);
    check("t3_issued8", 64'(issued_count), 64'd8);
    check("t3_addr", 64'(cmd_addr), 64'd256);
    check("t3_write", 64'(cmd_write), 64'd0);
    rsp_valid = 1'b1;
    tick();
    rsp_valid = 1'b0;
    check("t3_reopen", 64'(cmd_valid), 64'd1);
    repeat (5) begin
      if (cmd_valid) acc++;
      tick();
    end
    check("t3_accepts9", 64'(acc), 64'd9);
    check("t3_full_again", 64'(cmd_valid), 64'd0);
    start = 1'b0;
    tick();
    check("t3_drain_busy", 64'(busy), 64'd1);
    for (int k = 0; k < 8; k++) begin
      if (k == 7) check("t3_drain_last", 64'(busy), 64'd1);
      rsp_valid = 1'b1;
      tick();
      rsp_valid = 1'b0;
      tick();
    end
    check("t3_idle", 64'(busy), 64'd0);
    check("t3_issued", 64'(issued_count), 64'd9);
    check("t3_completed", 64'(completed_count), 64'd9);
    check("t3_err", 64'(err_unexpected), 64'd0);

    // Handshake hold while start falls.
    read_write = 3'd1; address_inc = 1'b1; cmd_ready = 1'b1; start = 1'b1;
    tick();
    tick();
    tick();
    rsp_valid = 1'b1; cmd_ready = 1'b0;
    tick();
    rsp_valid = 1'b0; start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("t4_valid%0d", i), 64'(cmd_valid), 64'd1);
      check($sformatf("t4_addr%0d", i), 64'(cmd_addr), 64'd32);
      check($sformatf("t4_write%0d", i), 64'(cmd_write), 64'd1);
    end
    cmd_ready = 1'b1;
    tick();
    check("t4_accepted", 64'(cmd_valid), 64'd0);
    check("t4_drain", 64'(busy), 64'd1);
    check("t4_issued", 64'(issued_count), 64'd2);
    tick();
    rsp_valid = 1'b1;
    tick();
    rsp_valid = 1'b0;
    check("t4_idle", 64'(busy), 64'd0);
    check("t4_completed", 64'(completed_count), 64'd2);

    // Address wrap on the 6-bit instance, then an unexpected response in IDLE.
    rw_w = 3'd1; inc_w = 1'b1; ready_w = 1'b1; start_w = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t5_addr%0d", i), 64'(addr_w), (i % 2 == 0) ? 64'd32 : 64'd0);
      check($sformatf("t5_valid%0d", i), 64'(valid_w), 64'd1);
      if (i == 2) start_w = 1'b0;
      tick();
      tick();
      rsp_w = 1'b1;
      tick();
      rsp_w = 1'b0;
    end
    check("t5_idle", 64'(busy_w), 64'd0);
    check("t5_write", 64'(write_w), 64'd1);
    rsp_w = 1'b1;
    tick();
    rsp_w = 1'b0;
    check("t5_err", 64'(err_w), 64'd1);
    check("t5_issued", 64'(issued_w), 64'd3);
    check("t5_completed", 64'(completed_w), 64'd3);

    // Invalid mode, then reset in the middle of a queued write run.
    read_write = 3'd6; start = 1'b1;
    tick();
    tick();
    check("t6_inv_busy", 64'(busy), 64'd0);
    check("t6_inv_valid", 64'(cmd_valid), 64'd0);
    check("t6_hold_issued", 64'(issued_count), 64'd2);
    start = 1'b0;
    tick();
    read_write = 3'd4; cmd_ready = 1'b1; start = 1'b1;
    tick();
    tick();
    tick();
    check("t6_run_write", 64'(cmd_write), 64'd1);
    check("t6_run_addr", 64'(cmd_addr), 64'd64);
    Reset_n = 1'b0;
    tick();
    check("t6_rst_valid", 64'(cmd_valid), 64'd0);
    check("t6_rst_write", 64'(cmd_write), 64'd0);
    check("t6_rst_addr", 64'(cmd_addr), 64'd0);
    check("t6_rst_busy", 64'(busy), 64'd0);
    check("t6_rst_issued", 64'(issued_count), 64'd0);
    check("t6_rst_completed", 64'(completed_count), 64'd0);
    check("t6_rst_err_w", 64'(err_w), 64'd0);
    Reset_n = 1'b1; start = 1'b0;
    tick();
    check("t6_after_busy", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
